// File: rtl/period_monitor_ctrl.sv
// period_monitor_ctrl
// Measures the spacing between synchronous event strobes, classifies each
// interval against a nominal period +/- tolerance and runs a lock/unlock
// sequence. Publishes the last interval, a lock flag and sticky
// too-short / too-long flags for a status register.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | disabled; counters cleared, events ignored
// ARM     | waiting for the first event to open a measurement
// MEASURE | counting cycles since the last event, checking each interval

module period_monitor_ctrl #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 10,
  parameter int TOL        = 1,
  parameter int N_LOCK     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             event_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             locked_o,
  output logic             too_short_o,
  output logic             too_long_o,
  output logic [1:0]       state_o
);

  // Width of the good-interval counter; it saturates at N_LOCK.
  localparam int GOOD_W = (N_LOCK < 2) ? 1 : $clog2(N_LOCK + 1);

  localparam logic [CNT_W-1:0]  MIN_P    = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0]  MAX_P    = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [GOOD_W-1:0] N_LOCK_G = GOOD_W'(N_LOCK);

  // The window must sit strictly inside the counter range so that an
  // overrun is always detected before cnt could wrap.
  if (!((TOL < EXP_PERIOD) &&
        (longint'(EXP_PERIOD) < ((longint'(1) << CNT_W) - longint'(TOL))))) begin : g_bad_window
    $error("period_monitor_ctrl: need TOL < EXP_PERIOD < 2**CNT_W - TOL");
  end

  if (N_LOCK < 1) begin : g_bad_lock
    $error("period_monitor_ctrl: N_LOCK must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic [CNT_W-1:0]  period_nxt;
  logic              valid_nxt;
  logic              locked_nxt;
  logic              short_nxt;
  logic              long_nxt;

  // Interval classification for the current cycle.
  logic [CNT_W-1:0]  p_cur;
  logic              is_short;
  logic              at_max;
  logic [GOOD_W-1:0] good_inc;

  // Interval that an event in this cycle would close, and its class.
  always_comb begin
    p_cur    = cnt + CNT_W'(1);
    is_short = (p_cur < MIN_P);
    at_max   = (p_cur == MAX_P);
    good_inc = (good_cnt == N_LOCK_G) ? good_cnt : good_cnt + GOOD_W'(1);
  end

  // State register plus all registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      good_cnt       <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      locked_o       <= 1'b0;
      too_short_o    <= 1'b0;
      too_long_o     <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      good_cnt       <= good_nxt;
      period_o       <= period_nxt;
      period_valid_o <= valid_nxt;
      locked_o       <= locked_nxt;
      too_short_o    <= short_nxt;
      too_long_o     <= long_nxt;
    end
  end

  // Next-state and next-result decode; a violation set beats a same-cycle clear.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    good_nxt   = good_cnt;
    period_nxt = period_o;
    valid_nxt  = 1'b0;
    locked_nxt = locked_o;
    short_nxt  = too_short_o & ~clr_i;
    long_nxt   = too_long_o & ~clr_i;

    if (!en) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      good_nxt   = '0;
      locked_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ARM;
          cnt_nxt   = '0;
        end

        ARM: begin
          if (event_i) begin
            state_nxt = MEASURE;
            cnt_nxt   = '0;
          end
        end

        MEASURE: begin
          if (event_i) begin
            period_nxt = p_cur;
            valid_nxt  = 1'b1;
            cnt_nxt    = '0;
            if (is_short) begin
              short_nxt  = 1'b1;
              locked_nxt = 1'b0;
              good_nxt   = '0;
            end else begin
              // Overrun fires at MAX, so any interval reaching here is in window.
              good_nxt = good_inc;
              if (good_inc == N_LOCK_G) begin
                locked_nxt = 1'b1;
              end
            end
          end else if (at_max) begin
            long_nxt   = 1'b1;
            locked_nxt = 1'b0;
            good_nxt   = '0;
            cnt_nxt    = '0;
            state_nxt  = ARM;
          end else begin
            cnt_nxt = p_cur;
          end
        end

        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          good_nxt  = '0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_period_monitor_ctrl.sv
// Directed bench for period_monitor_ctrl with EXP_PERIOD=10, TOL=1, N_LOCK=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each check sees the result of the edge just passed.

module tb_period_monitor_ctrl;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             event_i;
  logic             clr_i;
  logic [CNT_W-1:0] period_o;
  logic             period_valid_o;
  logic             locked_o;
  logic             too_short_o;
  logic             too_long_o;
  logic [1:0]       state_o;

  int n_checks = 0;
  int n_pass   = 0;

  period_monitor_ctrl #(
    .CNT_W      (CNT_W),
    .EXP_PERIOD (10),
    .TOL        (1),
    .N_LOCK     (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .event_i        (event_i),
    .clr_i          (clr_i),
    .period_o       (period_o),
    .period_valid_o (period_valid_o),
    .locked_o       (locked_o),
    .too_short_o    (too_short_o),
    .too_long_o     (too_long_o),
    .state_o        (state_o)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle event strobe; returns just after the edge that sampled it.
  task automatic pulse_event(input logic with_clr);
    event_i = 1'b1;
    clr_i   = with_clr;
    tick();
    event_i = 1'b0;
    clr_i   = 1'b0;
  endtask

  // Event closing an interval of p cycles since the previous event;
  // 'spent' cycles have already been ticked by the caller.
  task automatic interval(input int p, input int spent, input logic with_clr);
    repeat (p - 1 - spent) tick();
    pulse_event(with_clr);
  endtask

  initial begin
    rst_n   = 1'b1;
    en      = 1'b0;
    event_i = 1'b0;
    clr_i   = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    check_val("rst_state",  32'(state_o), 0);
    check_val("rst_period", 32'(period_o), 0);
    check_val("rst_valid",  32'(period_valid_o), 0);
    check_val("rst_flags",  32'({locked_o, too_short_o, too_long_o}), 0);
    rst_n = 1'b1;
    tick();

    // Enable, arm, first event opens measurement without a pulse.
    en = 1'b1;
    tick();
    check_val("arm_state", 32'(state_o), 1);
    pulse_event(1'b0);
    check_val("meas_state", 32'(state_o), 2);
    check_val("arm_no_valid", 32'(period_valid_o), 0);

    // Four nominal intervals; lock with the fourth pulse.
    for (int i = 0; i < 4; i++) begin
      interval(10, (i == 3) ? 0 : 0, 1'b0);
      check_val("nom_valid",  32'(period_valid_o), 1);
      check_val("nom_period", 32'(period_o), 10);
      check_val("nom_locked", 32'(locked_o), (i == 3) ? 1 : 0);
    end
    tick();
    check_val("valid_drop", 32'(period_valid_o), 0);
    check_val("lock_hold",  32'(locked_o), 1);

    // Short interval of 8 breaks lock, then relock after four good ones.
    interval(8, 1, 1'b0);
    check_val("short_period", 32'(period_o), 8);
    check_val("short_valid",  32'(period_valid_o), 1);
    check_val("short_flag",   32'(too_short_o), 1);
    check_val("short_unlock", 32'(locked_o), 0);
    check_val("short_state",  32'(state_o), 2);
    for (int i = 0; i < 4; i++) begin
      interval(10, 0, 1'b0);
      check_val("relock", 32'(locked_o), (i == 3) ? 1 : 0);
    end

    // Interval at MAX is good and keeps lock.
    interval(11, 0, 1'b0);
    check_val("max_period", 32'(period_o), 11);
    check_val("max_locked", 32'(locked_o), 1);
    check_val("max_nolong", 32'(too_long_o), 0);

    // No event: overrun after MAX cycles.
    repeat (10) tick();
    check_val("pre_overrun_long",  32'(too_long_o), 0);
    check_val("pre_overrun_state", 32'(state_o), 2);
    tick();
    check_val("overrun_long",   32'(too_long_o), 1);
    check_val("overrun_state",  32'(state_o), 1);
    check_val("overrun_valid",  32'(period_valid_o), 0);
    check_val("overrun_unlock", 32'(locked_o), 0);
    repeat (3) tick();
    pulse_event(1'b0);
    check_val("rearm_state", 32'(state_o), 2);
    check_val("rearm_valid", 32'(period_valid_o), 0);

    // clr with a same-cycle short violation: short stays set, long clears.
    interval(7, 0, 1'b1);
    check_val("clr_set_short",  32'(too_short_o), 1);
    check_val("clr_set_long",   32'(too_long_o), 0);
    check_val("clr_set_period", 32'(period_o), 7);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check_val("clr_only_short", 32'(too_short_o), 0);
    check_val("clr_only_long",  32'(too_long_o), 0);

    // Async reset between edges mid-MEASURE.
    interval(3, 1, 1'b0);
    check_val("pre_rst_short", 32'(too_short_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_period", 32'(period_o), 0);
    check_val("async_short",  32'(too_short_o), 0);
    check_val("async_state",  32'(state_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("post_rst_arm", 32'(state_o), 1);
    pulse_event(1'b0);
    interval(2, 0, 1'b0);
    for (int i = 0; i < 4; i++) interval(10, 0, 1'b0);
    check_val("pre_dis_locked", 32'(locked_o), 1);
    check_val("pre_dis_short",  32'(too_short_o), 1);
    repeat (3) tick();

    // Disable mid-MEASURE: IDLE, unlock, keep period and flags.
    en = 1'b0;
    tick();
    check_val("dis_state",  32'(state_o), 0);
    check_val("dis_locked", 32'(locked_o), 0);
    check_val("dis_short",  32'(too_short_o), 1);
    check_val("dis_period", 32'(period_o), 10);
    pulse_event(1'b0);
    check_val("idle_ignore", 32'(period_valid_o), 0);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check_val("idle_clr", 32'(too_short_o), 0);

    // Back-to-back events in MEASURE.
    en = 1'b1;
    tick();
    pulse_event(1'b0);
    event_i = 1'b1;
    tick();
    check_val("b2b_valid1",  32'(period_valid_o), 1);
    check_val("b2b_period1", 32'(period_o), 1);
    tick();
    check_val("b2b_valid2",  32'(period_valid_o), 1);
    check_val("b2b_period2", 32'(period_o), 1);
    check_val("b2b_short",   32'(too_short_o), 1);
    event_i = 1'b0;
    tick();
    check_val("b2b_drop", 32'(period_valid_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/period_monitor_ctrl.md
Name: period_monitor_ctrl

Overview:
Single-clock controller that measures the interval between synchronous event strobes, checks each interval against a programmed nominal period and tolerance, and sequences a lock/unlock state machine. It is the runtime counterpart to the static clock-period constraints: it sits beside clock-fed counters and reports whether the strobe they produce runs at the constrained rate. Results are a registered period value, a lock indication and sticky violation flags for a status register.

Parameters:
CNT_W, 16, width of the interval counter and period_o
EXP_PERIOD, 10, nominal interval in clk cycles; elaboration error unless TOL < EXP_PERIOD < 2^CNT_W - TOL
TOL, 1, allowed deviation in cycles; valid window MIN = EXP_PERIOD-TOL to MAX = EXP_PERIOD+TOL, inclusive
N_LOCK, 4, consecutive in-window intervals required to assert locked_o; must be at least 1

Ports:
clk  input  1  block clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  enable; low forces IDLE
event_i  input  1  synchronous event strobe; any cycle with event_i=1 is one event
clr_i  input  1  clears the sticky flags too_short_o and too_long_o
period_o  output  CNT_W  last measured interval in cycles
period_valid_o  output  1  one-cycle pulse when period_o updates
locked_o  output  1  N_LOCK consecutive good intervals seen, none bad since
too_short_o  output  1  sticky: an interval below MIN occurred
too_long_o  output  1  sticky: no event within MAX cycles
state_o  output  2  IDLE=0, ARM=1, MEASURE=2

Behaviour:
- Reset, asynchronous and immediate: all outputs 0, state IDLE, internal cnt=0, good_cnt=0.
- IDLE: if en=1, move to ARM next cycle. Events are ignored in IDLE.
- ARM: an event moves the block to MEASURE with cnt<=0. No period_valid_o is produced. No timeout applies in ARM.
- MEASURE, interval definition: events at cycles t and t+P give interval P. cnt increments each MEASURE cycle without an event, so at an event the interval is P = cnt+1.
- MEASURE, event with MIN <= P <= MAX:
  - period_o <= P and period_valid_o=1 in the following cycle (latency 1).
  - good_cnt increments and saturates at N_LOCK.
  - locked_o <= 1 in the same cycle as the valid pulse when good_cnt reaches N_LOCK.
  - cnt <= 0.
- MEASURE, event with P < MIN:
  - period_o <= P and period_valid_o pulses.
  - too_short_o <= 1, locked_o <= 0, good_cnt <= 0.
  - cnt <= 0; the block stays in MEASURE.
- MEASURE, overrun: in a cycle with no event and cnt+1 == MAX:
  - too_long_o <= 1, locked_o <= 0, good_cnt <= 0.
  - state <= ARM; no period_valid_o pulse.
  - too_long_o is therefore visible at cycle t+MAX+1 after the last event at t.
  - An event arriving exactly at interval MAX is good and does not overrun.
- en=0 in any state: next cycle state=IDLE, cnt=0, good_cnt=0, locked_o=0. period_o and the sticky flags are retained.
- clr_i clears both sticky flags next cycle. If a new violation occurs in the same cycle as clr_i, the set wins and the flag stays 1.
- period_valid_o is never high for two consecutive cycles unless events occur on consecutive cycles.
- cnt never wraps: MAX < 2^CNT_W guarantees overrun is detected first.
- state_o reflects the registered state.

Test Plan:
- EXP=10, TOL=1, N_LOCK=4; en=1; events every 10 cycles, 5 events → 4 valid pulses each with period_o=10; locked_o rises with the 4th pulse, one cycle after the 5th event.
- From lock, one interval of 8 → period_o=8, too_short_o=1, locked_o=0 in the same cycle; next 4 intervals of 10 → relock.
- Interval of 11 → accepted, locked unaffected. Then no event for 11 cycles after the last event → too_long_o=1 at cycle t+12, state_o=ARM, no valid pulse. The next event re-arms without a pulse.
- clr_i asserted in the cycle a 7-cycle interval ends → too_short_o remains 1. clr_i alone later → both flags 0 next cycle.
- rst_n low mid-MEASURE, between clock edges → all outputs 0 immediately. Release, then en=0 mid-MEASURE with flags set → IDLE next cycle, locked_o=0, flags and period_o held.
- Events on consecutive cycles in MEASURE (P=1 < MIN) → back-to-back valid pulses with period_o=1 and too_short_o=1.
